// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
//   Command-frame controller sitting behind the UART receiver. Bytes are
//   sequenced through a fixed 5-byte frame: HEADER, ADDR, DATA_H, DATA_L, CHK.
//   CHK must equal the 8-bit sum (carries dropped) of ADDR+DATA_H+DATA_L.
//   A good frame produces a one-cycle reg_wr_en strobe with the address and
//   data updated in the same cycle. A bad checksum, or more than TIMEOUT_CNT
//   cycles between accepted bytes inside a frame, drops the frame and pulses
//   frame_err for one cycle.
//
//   Optional feature macro: UART_FRAME_ACK_EN
//     Adds ack_valid/ack_data, which report ACK (8'h06) alongside reg_wr_en
//     or NAK (8'h15) alongside frame_err, for a UART transmitter start input.
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst_n    in   synchronous active-low reset
//   uart_done    in   receiver byte-complete flag (may be high many cycles)
//   uart_data    in   received byte, valid while uart_done is high
//   reg_wr_en    out  one-cycle register write strobe
//   reg_wr_addr  out  write address, held until the next write
//   reg_wr_data  out  write data {DATA_H, DATA_L}, held until the next write
//   frame_err    out  one-cycle pulse on checksum error or timeout
//   busy         out  high whenever a frame is in progress
//   ack_valid    out  (UART_FRAME_ACK_EN only) one-cycle ACK/NAK strobe
//   ack_data     out  (UART_FRAME_ACK_EN only) ACK/NAK byte, held

module uart_frame_ctrl #(
   parameter logic [7:0]  HEADER      = 8'hA5,
   parameter logic [31:0] TIMEOUT_CNT = 32'd500000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        uart_done,
   input  logic [7:0]  uart_data,
   output logic        reg_wr_en,
   output logic [7:0]  reg_wr_addr,
   output logic [15:0] reg_wr_data,
   output logic        frame_err,
`ifdef UART_FRAME_ACK_EN
   output logic        ack_valid,
   output logic [7:0]  ack_data,
`endif
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DH,
      DL,
      CHK
   } state_t;

   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

   state_t      state;
   logic        done_d;
   logic        byte_stb;
   logic [31:0] to_cnt;
   logic [7:0]  csum;
   logic [7:0]  addr_q;
   logic [7:0]  data_h_q;
   logic [7:0]  data_l_q;

   // One byte per rising edge of uart_done, however long it stays high.
   assign byte_stb = uart_done & ~done_d;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         done_d      <= 1'b0;
         to_cnt      <= '0;
         csum        <= '0;
         addr_q      <= '0;
         data_h_q    <= '0;
         data_l_q    <= '0;
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
`ifdef UART_FRAME_ACK_EN
         ack_valid   <= 1'b0;
         ack_data    <= '0;
`endif
      end else begin
         done_d    <= uart_done;
         reg_wr_en <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_FRAME_ACK_EN
         ack_valid <= 1'b0;
`endif
         case (state)
            IDLE: begin
               to_cnt <= '0;
               // Non-header bytes are discarded silently.
               if (byte_stb && (uart_data == HEADER)) begin
                  state <= ADDR;
                  busy  <= 1'b1;
                  csum  <= '0;
               end
            end
            default: begin
               // A byte arriving in the expiry cycle wins over the timeout.
               if (byte_stb) begin
                  to_cnt <= '0;
                  case (state)
                     ADDR: begin
                        addr_q <= uart_data;
                        csum   <= uart_data;
                        state  <= DH;
                     end
                     DH: begin
                        data_h_q <= uart_data;
                        csum     <= csum + uart_data;
                        state    <= DL;
                     end
                     DL: begin
                        data_l_q <= uart_data;
                        csum     <= csum + uart_data;
                        state    <= CHK;
                     end
                     CHK: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (uart_data == csum) begin
                           reg_wr_en   <= 1'b1;
                           reg_wr_addr <= addr_q;
                           reg_wr_data <= {data_h_q, data_l_q};
`ifdef UART_FRAME_ACK_EN
                           ack_valid   <= 1'b1;
                           ack_data    <= ACK_BYTE;
`endif
                        end else begin
                           frame_err <= 1'b1;
`ifdef UART_FRAME_ACK_EN
                           ack_valid <= 1'b1;
                           ack_data  <= NAK_BYTE;
`endif
                        end
                     end
                     default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  endcase
               end else if (to_cnt == (TIMEOUT_CNT - 32'd1)) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  to_cnt    <= '0;
                  frame_err <= 1'b1;
`ifdef UART_FRAME_ACK_EN
                  ack_valid <= 1'b1;
                  ack_data  <= NAK_BYTE;
`endif
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl
//   Directed self-checking bench for uart_frame_ctrl, built with
//   TIMEOUT_CNT=100 so the inter-byte timeout can be reached quickly.
//   Bytes are spaced 50 cycles apart (40 high, 10 low) unless a test
//   deliberately places them on the timeout boundary.

`timescale 1ns/1ps

module tb_uart_frame_ctrl;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        uart_done;
   logic [7:0]  uart_data;
   logic        reg_wr_en;
   logic [7:0]  reg_wr_addr;
   logic [15:0] reg_wr_data;
   logic        frame_err;
   logic        busy;
`ifdef UART_FRAME_ACK_EN
   logic        ack_valid;
   logic [7:0]  ack_data;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cycle  = 0;
   int unsigned wr_cnt = 0;
   int unsigned err_cnt = 0;
   int unsigned err_cycle = 0;
   int unsigned last_stb = 0;
   int unsigned ack_cnt = 0;
   int unsigned ack_misalign = 0;
   logic [7:0]  last_ack = 8'h00;

   uart_frame_ctrl #(
      .HEADER      (8'hA5),
      .TIMEOUT_CNT (32'd100)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .uart_done   (uart_done),
      .uart_data   (uart_data),
      .reg_wr_en   (reg_wr_en),
      .reg_wr_addr (reg_wr_addr),
      .reg_wr_data (reg_wr_data),
      .frame_err   (frame_err),
`ifdef UART_FRAME_ACK_EN
      .ack_valid   (ack_valid),
      .ack_data    (ack_data),
`endif
      .busy        (busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cycle++;

   // Pulse counters: counting high cycles also proves single-cycle width.
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (reg_wr_en) wr_cnt++;
         if (frame_err) begin
            err_cnt++;
            err_cycle = cycle;
         end
`ifdef UART_FRAME_ACK_EN
         if (ack_valid) begin
            ack_cnt++;
            last_ack = ack_data;
         end
         if (ack_valid !== (reg_wr_en | frame_err)) ack_misalign++;
`endif
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called #1 after a posedge; the byte_stb edge is the next posedge.
   task automatic send_byte(input logic [7:0] b, input int unsigned hi, input int unsigned lo);
      uart_data = b;
      uart_done = 1'b1;
      last_stb  = cycle + 1;
      repeat (hi) @(posedge sys_clk);
      #1;
      uart_done = 1'b0;
      uart_data = 8'h00;
      repeat (lo) @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      send_byte(b, 40, 10);
   endtask

   int unsigned wr0;
   int unsigned er0;
   int unsigned ak0;

   initial begin
      sys_rst_n = 1'b0;
      uart_done = 1'b0;
      uart_data = 8'h00;
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      check("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
      check("rst_addr", {24'd0, reg_wr_addr}, 32'd0);
      check("rst_data", {16'd0, reg_wr_data}, 32'd0);
      check("rst_err", {31'd0, frame_err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;

      // 1: good frame
      wr0 = wr_cnt; er0 = err_cnt; ak0 = ack_cnt;
      send(8'hA5);
      check("t1_busy_mid", {31'd0, busy}, 32'd1);
      send(8'h10); send(8'h12); send(8'h34); send(8'h56);
      check("t1_wr", wr_cnt - wr0, 32'd1);
      check("t1_err", err_cnt - er0, 32'd0);
      check("t1_addr", {24'd0, reg_wr_addr}, 32'h10);
      check("t1_data", {16'd0, reg_wr_data}, 32'h1234);
      check("t1_busy", {31'd0, busy}, 32'd0);
`ifdef UART_FRAME_ACK_EN
      check("t1_ack_cnt", ack_cnt - ak0, 32'd1);
      check("t1_ack_data", {24'd0, last_ack}, 32'h06);
`endif

      // 2: checksum error
      wr0 = wr_cnt; er0 = err_cnt; ak0 = ack_cnt;
      send(8'hA5); send(8'h10); send(8'h12); send(8'h34); send(8'h57);
      check("t2_wr", wr_cnt - wr0, 32'd0);
      check("t2_err", err_cnt - er0, 32'd1);
      check("t2_addr", {24'd0, reg_wr_addr}, 32'h10);
      check("t2_data", {16'd0, reg_wr_data}, 32'h1234);
      check("t2_busy", {31'd0, busy}, 32'd0);
`ifdef UART_FRAME_ACK_EN
      check("t2_ack_cnt", ack_cnt - ak0, 32'd1);
      check("t2_ack_data", {24'd0, last_ack}, 32'h15);
`endif

      // 3: leading junk ignored
      wr0 = wr_cnt; er0 = err_cnt;
      send(8'h00); send(8'hFF);
      check("t3_busy_junk", {31'd0, busy}, 32'd0);
      send(8'hA5); send(8'h01); send(8'h00); send(8'h02); send(8'h03);
      check("t3_wr", wr_cnt - wr0, 32'd1);
      check("t3_err", err_cnt - er0, 32'd0);
      check("t3_addr", {24'd0, reg_wr_addr}, 32'h01);
      check("t3_data", {16'd0, reg_wr_data}, 32'h0002);

      // 4: timeout after ADDR byte, then recovery
      wr0 = wr_cnt; er0 = err_cnt;
      send(8'hA5); send(8'h10);
      for (int i = 0; i < 200 && err_cnt == er0; i++) @(posedge sys_clk);
      #1;
      check("t4_err", err_cnt - er0, 32'd1);
      check("t4_latency", err_cycle - last_stb, 32'd100);
      check("t4_busy", {31'd0, busy}, 32'd0);
      check("t4_wr", wr_cnt - wr0, 32'd0);
      send(8'hA5); send(8'h20); send(8'h00); send(8'h01); send(8'h21);
      check("t4_wr_after", wr_cnt - wr0, 32'd1);
      check("t4_addr", {24'd0, reg_wr_addr}, 32'h20);
      check("t4_data", {16'd0, reg_wr_data}, 32'h0001);

      // 5: reset mid-frame
      wr0 = wr_cnt; er0 = err_cnt;
      send(8'hA5); send(8'h10); send(8'h12);
      sys_rst_n = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      check("t5_rst_addr", {24'd0, reg_wr_addr}, 32'd0);
      check("t5_rst_data", {16'd0, reg_wr_data}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
      check("t5_rst_err", {31'd0, frame_err}, 32'd0);
      @(posedge sys_clk);
      #1;
      send(8'hA5); send(8'h30); send(8'hAB); send(8'hCD); send(8'hA8);
      check("t5_wr", wr_cnt - wr0, 32'd1);
      check("t5_err", err_cnt - er0, 32'd0);
      check("t5_addr", {24'd0, reg_wr_addr}, 32'h30);
      check("t5_data", {16'd0, reg_wr_data}, 32'hABCD);

      // 6: bytes exactly TIMEOUT_CNT cycles apart are still accepted
      wr0 = wr_cnt; er0 = err_cnt;
      send_byte(8'hA5, 50, 50); send_byte(8'h40, 50, 50);
      send_byte(8'h00, 50, 50); send_byte(8'h00, 50, 50);
      send_byte(8'h40, 50, 50);
      check("t6_wr", wr_cnt - wr0, 32'd1);
      check("t6_err", err_cnt - er0, 32'd0);
      check("t6_addr", {24'd0, reg_wr_addr}, 32'h40);
      check("t6_data", {16'd0, reg_wr_data}, 32'h0000);

      // 7: one cycle later the frame has already timed out
      wr0 = wr_cnt; er0 = err_cnt;
      send_byte(8'hA5, 50, 51); send(8'h41);
      check("t7_err", err_cnt - er0, 32'd1);
      check("t7_wr", wr_cnt - wr0, 32'd0);
      check("t7_busy", {31'd0, busy}, 32'd0);
      check("t7_addr", {24'd0, reg_wr_addr}, 32'h40);

`ifdef UART_FRAME_ACK_EN
      check("ack_align", ack_misalign, 32'd0);
      check("ack_total", ack_cnt, wr_cnt + err_cnt);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
